// File: rtl/udcnt_ctl.sv
// Up/down counter controller: reload register, RUN/IDLE sequencing and
// terminal-count detection over a carry-chained bank of 1-bit slices.
module udcnt_ctl #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         resl,
   input  logic         wr,
   input  logic [W-1:0] din,
   input  logic         start,
   input  logic         stop,
   input  logic         ce,
   input  logic         up,
   input  logic         mode,
   output logic [W-1:0] cnt,
   output logic         tc,
   output logic         busy
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state, state_nx;
   logic [W-1:0] rl;
   logic [W-1:0] cnt_nx;
   logic [W-1:0] stepped;
   logic [W:0]   ci;
   logic         co;
   logic         tc_nx;

   // Ripple chain: each slice toggles on carry-in and passes carry when
   // its bit equals the direction (all-ones going up, all-zeros going down).
   always_comb begin
      ci[0]   = ce & (state == RUN);
      stepped = '0;
      for (int unsigned i = 0; i < W; i++) begin
         ci[i+1]    = ci[i] & ~(cnt[i] ^ up);
         stepped[i] = cnt[i] ^ ci[i];
      end
   end

   assign co = ci[W];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tc_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               cnt_nx   = rl;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_nx = IDLE;
            end else if (start) begin
               cnt_nx = rl;
            end else if (co) begin
               // Terminal reload replaces the wrap the chain would produce.
               cnt_nx = rl;
               tc_nx  = 1'b1;
               if (!mode) state_nx = IDLE;
            end else begin
               cnt_nx = stepped;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resl) begin
      if (!resl) begin
         state <= IDLE;
         cnt   <= '0;
         rl    <= '0;
         tc    <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         tc    <= tc_nx;
         if (wr) rl <= din;
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_udcnt_ctl.sv
// Self-checking bench for udcnt_ctl: arithmetic reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_udcnt_ctl;
   localparam int W = 16;
   localparam logic [W-1:0] MAXV = '1;

   logic         clk = 1'b0;
   logic         resl;
   logic         wr, start, stop, ce, up, mode;
   logic [W-1:0] din;
   logic [W-1:0] cnt;
   logic         tc, busy;

   int checks = 0;
   int errors = 0;

   udcnt_ctl #(.W(W)) dut (
      .clk(clk), .resl(resl), .wr(wr), .din(din), .start(start),
      .stop(stop), .ce(ce), .up(up), .mode(mode),
      .cnt(cnt), .tc(tc), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer counting, terminal when the next step
   // would leave the representable range.
   logic [W-1:0] m_cnt, m_rl;
   logic         m_run, m_tc;

   always @(posedge clk or negedge resl) begin
      if (!resl) begin
         m_cnt <= '0; m_rl <= '0; m_run <= 1'b0; m_tc <= 1'b0;
      end else begin
         m_tc <= 1'b0;
         if (wr) m_rl <= din;
         if (!m_run) begin
            if (start && !stop) begin
               m_cnt <= m_rl;
               m_run <= 1'b1;
            end
         end else if (stop) begin
            m_run <= 1'b0;
         end else if (start) begin
            m_cnt <= m_rl;
         end else if (ce) begin
            if ((up && m_cnt == MAXV) || (!up && m_cnt == 0)) begin
               m_cnt <= m_rl;
               m_tc  <= 1'b1;
               if (!mode) m_run <= 1'b0;
            end else begin
               m_cnt <= up ? W'(int'(m_cnt) + 1) : W'(int'(m_cnt) - 1);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_cnt", int'(cnt), int'(m_cnt));
      check("model_tc", int'(tc), int'(m_tc));
      check("model_busy", int'(busy), int'(m_run));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect3(input string name, input int c, input int t, input int b);
      check({name, "_cnt"}, int'(cnt), c);
      check({name, "_tc"}, int'(tc), t);
      check({name, "_busy"}, int'(busy), b);
   endtask

   task automatic load(input logic [W-1:0] v);
      wr = 1'b1; din = v;
      cyc();
      wr = 1'b0;
   endtask

   initial begin
      resl = 1'b0; wr = 0; start = 0; stop = 0; ce = 0; up = 0; mode = 0; din = '0;
      repeat (2) cyc();
      resl = 1'b1;
      cyc();
      expect3("reset", 0, 0, 0);

      // Reset in the middle of RUN
      load(16'h1234);
      start = 1; cyc(); start = 0;
      expect3("run1234", 'h1234, 0, 1);
      cyc();
      @(posedge clk); #3; resl = 1'b0; #1;
      expect3("async_rst", 0, 0, 0);
      cyc(); resl = 1'b1;
      ce = 1; repeat (3) cyc();
      expect3("idle_ce", 0, 0, 0);
      ce = 0;

      // One-shot down from 3
      load(3);
      mode = 0; up = 0; ce = 1; start = 1; cyc(); start = 0;
      expect3("os_3", 3, 0, 1);
      cyc(); expect3("os_2", 2, 0, 1);
      cyc(); expect3("os_1", 1, 0, 1);
      cyc(); expect3("os_0", 0, 0, 1);
      cyc(); expect3("os_term", 3, 1, 0);
      cyc(); expect3("os_hold", 3, 0, 0);
      ce = 0;

      // Auto-reload up, tick every other cycle
      load(16'hFFFD);
      mode = 1; up = 1; start = 1; cyc(); start = 0;
      expect3("ar_fffd", 'hFFFD, 0, 1);
      ce = 1; cyc(); ce = 0; expect3("ar_fffe", 'hFFFE, 0, 1);
      cyc();
      ce = 1; cyc(); ce = 0; expect3("ar_ffff", 'hFFFF, 0, 1);
      cyc();
      ce = 1; cyc(); ce = 0; expect3("ar_term", 'hFFFD, 1, 1);
      cyc(); expect3("ar_after", 'hFFFD, 0, 1);
      for (int i = 0; i < 12; i++) begin
         ce = (i % 2 == 0); cyc();
      end
      ce = 0; stop = 1; cyc(); stop = 0;
      expect3("ar_stop", int'(m_cnt), 0, 0);

      // stop beats start
      load(9);
      up = 0; start = 1; cyc(); start = 0;
      ce = 1; repeat (4) cyc(); ce = 0;
      expect3("pr_5", 5, 0, 1);
      start = 1; stop = 1; cyc(); stop = 0;
      expect3("pr_both", 5, 0, 0);
      cyc(); start = 0;
      expect3("pr_restart", 9, 0, 1);
      ce = 1; cyc();
      start = 1; cyc(); start = 0;
      expect3("pr_discard", 9, 0, 1);
      ce = 0; stop = 1; cyc(); stop = 0;

      // Reload write during RUN
      load(10);
      mode = 1; up = 0; start = 1; cyc(); start = 0;
      ce = 1; repeat (6) cyc();
      expect3("wr_4", 4, 0, 1);
      wr = 1; din = 20; cyc(); wr = 0;
      expect3("wr_3", 3, 0, 1);
      repeat (3) cyc();
      expect3("wr_0", 0, 0, 1);
      cyc(); expect3("wr_term", 20, 1, 1);
      cyc(); expect3("wr_19", 19, 0, 1);
      ce = 0;

      // Simultaneous wr and start uses old rl
      wr = 1; din = 7; start = 1; cyc(); wr = 0; start = 0;
      expect3("ws_old", 20, 0, 1);
      stop = 1; cyc(); stop = 0;
      start = 1; cyc(); start = 0;
      expect3("ws_new", 7, 0, 1);
      stop = 1; cyc(); stop = 0;

      // rl=0 down auto-reload: continuous terminals, then turn up
      load(0);
      mode = 1; up = 0; start = 1; cyc(); start = 0;
      ce = 1;
      cyc(); expect3("deg_t1", 0, 1, 1);
      cyc(); expect3("deg_t2", 0, 1, 1);
      cyc(); expect3("deg_t3", 0, 1, 1);
      up = 1;
      cyc(); expect3("deg_1", 1, 0, 1);
      cyc(); expect3("deg_2", 2, 0, 1);
      cyc(); expect3("deg_3", 3, 0, 1);
      ce = 0; stop = 1; cyc(); stop = 0;

      // rl=all-ones up one-shot: immediate terminal
      load(16'hFFFF);
      mode = 0; up = 1; start = 1; cyc(); start = 0;
      ce = 1;
      cyc(); expect3("max_term", 'hFFFF, 1, 0);
      cyc(); expect3("max_idle", 'hFFFF, 0, 0);
      ce = 0;
      repeat (2) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, limit 20000");
      $fatal(1);
   end
endmodule
